// File: rtl/bsg_mem_link_pkg.sv
// Shared definitions for the memory-command link: BedRock opcodes, the
// serializer state encoding and the header-to-beat-count decode.
package bsg_mem_link_pkg;

    localparam logic [3:0] e_mem_wr    = 4'b0001;
    localparam logic [3:0] e_mem_uc_wr = 4'b0011;

    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_hdr  = 2'd1,
        e_data = 2'd2
    } link_state_e;

    // Write-data beats carried by a command; size 7 is illegal and is
    // treated as the largest legal transfer so the link never wedges.
    function automatic logic [3:0] mem_cmd_beats(input logic [3:0] opcode,
                                                 input logic [2:0] size);
        if (opcode != e_mem_wr && opcode != e_mem_uc_wr) return 4'd0;
        if (size < 3'd3) return 4'd1;
        if (size == 3'd7) return 4'd8;
        return 4'd1 << (size - 3'd3);
    endfunction

endpackage

// File: rtl/bsg_flit_piso.sv
// Parallel-in/serial-out register: loads a word, presents it one flit at a
// time (low-order first) and flags the last flit; the top is zero-padded.
module bsg_flit_piso #(
    parameter int width_p      = 64,
    parameter int flit_width_p = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic [width_p-1:0]      data,
    input  logic                    shift,
    output logic [flit_width_p-1:0] flit,
    output logic                    valid,
    output logic                    last
);

    localparam int flits_lp  = (width_p + flit_width_p - 1) / flit_width_p;
    localparam int padded_lp = flits_lp * flit_width_p;
    localparam int cnt_w_lp  = (flits_lp > 1) ? $clog2(flits_lp) : 1;

    logic [padded_lp-1:0] sr;
    logic [cnt_w_lp-1:0]  cnt;

    assign flit = sr[flit_width_p-1:0];
    assign last = (cnt == cnt_w_lp'(flits_lp - 1));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    // A load in the same cycle as the final shift wins: that is how the
    // next word follows the previous one with no bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr    <= '0;
            cnt   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            sr    <= padded_lp'(data);
            cnt   <= '0;
            valid <= 1'b1;
        end else if (shift && valid) begin
            sr    <= sr >> flit_width_p;
            cnt   <= last ? '0 : cnt + 1'b1;
            valid <= !last;
        end
    end

endmodule

// File: rtl/bsg_mem_cmd_link_tx.sv
// Serializes one mem_cmd header and its write-data beats onto a narrow
// valid/ready link: all header flits first, then beat_flits flits per beat.
module bsg_mem_cmd_link_tx
    import bsg_mem_link_pkg::*;
#(
    parameter int header_width_p = 80,
    parameter int dword_width_p  = 64,
    parameter int flit_width_p   = 32,  // must divide dword_width_p
    parameter int opcode_lsb_p   = 0,
    parameter int size_lsb_p     = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [header_width_p-1:0] mem_cmd_header_i,
    input  logic                      mem_cmd_header_v_i,
    output logic                      mem_cmd_header_ready_o,
    input  logic [dword_width_p-1:0]  mem_cmd_data_i,
    input  logic                      mem_cmd_data_v_i,
    output logic                      mem_cmd_data_ready_o,
    output logic [flit_width_p-1:0]   link_data_o,
    output logic                      link_v_o,
    input  logic                      link_ready_i
);

    link_state_e state, state_n;

    logic [3:0]              cmd_beats;
    logic [3:0]              beats_left;
    logic                    has_data;
    logic                    more_beats;
    logic [flit_width_p-1:0] hdr_flit, data_flit;
    logic                    hdr_valid, data_valid;
    logic                    hdr_last, data_last;
    logic                    hdr_hs, data_hs, link_hs;
    logic                    hdr_last_hs, data_last_hs;

    assign cmd_beats = mem_cmd_beats(mem_cmd_header_i[opcode_lsb_p +: 4],
                                     mem_cmd_header_i[size_lsb_p +: 3]);

    assign mem_cmd_header_ready_o = (state == e_idle);
    assign hdr_hs  = mem_cmd_header_v_i && mem_cmd_header_ready_o;

    assign link_v_o = ((state == e_hdr) && hdr_valid)
                   || ((state == e_data) && data_valid);
    assign link_hs  = link_v_o && link_ready_i;

    assign hdr_last_hs  = (state == e_hdr)  && link_hs && hdr_last;
    assign data_last_hs = (state == e_data) && link_hs && data_last;

    // beats_left counts beats not yet taken from the source, so the data
    // window closes exactly when the command's last beat is consumed.
    assign more_beats = (beats_left != 4'd0);
    assign mem_cmd_data_ready_o = ((state == e_data) && more_beats
                                   && (!data_valid || data_last_hs))
                               || (hdr_last_hs && has_data);
    assign data_hs = mem_cmd_data_v_i && mem_cmd_data_ready_o;

    bsg_flit_piso #(
        .width_p      (header_width_p),
        .flit_width_p (flit_width_p)
    ) hdr_piso (
        .clk     (clk_i),
        .reset_n (reset_n_i),
        .load    (hdr_hs),
        .data    (mem_cmd_header_i),
        .shift   ((state == e_hdr) && link_hs),
        .flit    (hdr_flit),
        .valid   (hdr_valid),
        .last    (hdr_last)
    );

    bsg_flit_piso #(
        .width_p      (dword_width_p),
        .flit_width_p (flit_width_p)
    ) data_piso (
        .clk     (clk_i),
        .reset_n (reset_n_i),
        .load    (data_hs),
        .data    (mem_cmd_data_i),
        .shift   ((state == e_data) && link_hs),
        .flit    (data_flit),
        .valid   (data_valid),
        .last    (data_last)
    );

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        case (state)
            e_idle:  if (hdr_hs)      state_n = e_hdr;
            e_hdr:   if (hdr_last_hs) state_n = has_data ? e_data : e_idle;
            e_data:  if (data_last_hs && !more_beats) state_n = e_idle;
            default: state_n = e_idle;
        endcase
    end

    always_comb begin
        link_data_o = '0;
        case (state)
            e_hdr:   link_data_o = hdr_flit;
            e_data:  link_data_o = data_flit;
            default: link_data_o = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= e_idle;
            beats_left <= 4'd0;
            has_data   <= 1'b0;
        end else begin
            state <= state_n;
            if (hdr_hs) begin
                beats_left <= cmd_beats;
                has_data   <= (cmd_beats != 4'd0);
            end else if (data_hs) begin
                beats_left <= beats_left - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_bsg_mem_cmd_link_tx.sv
// Scoreboard bench for bsg_mem_cmd_link_tx: directed commands push expected
// flits into a queue, and a link monitor pops and compares on each handshake.
module tb_bsg_mem_cmd_link_tx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [79:0] hdr;
    logic        hv, hready;
    logic [63:0] data;
    logic        dv, dready;
    logic [31:0] link_data;
    logic        link_v, link_ready;

    always #5 clk = ~clk;

    bsg_mem_cmd_link_tx dut (
        .clk_i                  (clk),
        .reset_n_i              (reset_n),
        .mem_cmd_header_i       (hdr),
        .mem_cmd_header_v_i     (hv),
        .mem_cmd_header_ready_o (hready),
        .mem_cmd_data_i         (data),
        .mem_cmd_data_v_i       (dv),
        .mem_cmd_data_ready_o   (dready),
        .link_data_o            (link_data),
        .link_v_o               (link_v),
        .link_ready_i           (link_ready)
    );

    typedef struct {
        logic [79:0] hdr;
        int          prior;
    } hdr_item_t;

    hdr_item_t   hdr_q[$];
    logic [31:0] exp_q[$];
    logic [63:0] src_q[$];

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    int flits_done = 0, exp_total = 0, beats_consumed = 0;
    int span_start = -1, span_end = -1;
    int gap = 0, starve_at = -1, starve_len = 0, pidx = 0;
    logic rdy_toggle = 1'b0, dready_seen = 1'b0, lat_pend = 1'b0;
    logic h_hs, d_hs;
    logic stall_pend = 1'b0;
    logic [31:0] held;
    logic [3:0]  pat = 4'b1001;  // link_ready sequence 1,0,0,1

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Link monitor: stability during stalls and scoreboard pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stall_pend = 1'b0;
            end else begin
                if (stall_pend) begin
                    check("stall_valid", link_v, 1);
                    check("stall_data", link_data, held);
                end
                if (link_v && link_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL extra_flit: got %h, expected no flit", link_data);
                    end else begin
                        check("flit", link_data, exp_q[0]);
                        exp_q.delete(0);
                    end
                    flits_done++;
                    if (span_start < 0) span_start = cyc;
                    span_end = cyc;
                end
                stall_pend = link_v && !link_ready;
                held = link_data;
            end
        end
    end

    task automatic drive();
        hv   = (hdr_q.size() > 0);
        hdr  = hv ? hdr_q[0].hdr : '0;
        if (gap > 0) begin
            dv = 1'b0;
            gap--;
        end else begin
            dv = (src_q.size() > 0);
        end
        data = (src_q.size() > 0) ? src_q[0] : '0;
        link_ready = rdy_toggle ? pat[pidx % 4] : 1'b1;
        pidx++;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        h_hs = hv && hready;
        d_hs = dv && dready;
        if (dready) dready_seen = 1'b1;
        if (lat_pend) begin
            check("hdr_latency_v", link_v, 1);
            lat_pend = 1'b0;
        end
        if (h_hs) check("hdr_accept_gate", flits_done, hdr_q[0].prior);
        @(posedge clk);
        #1;
        if (h_hs) begin
            hdr_q.delete(0);
            lat_pend = 1'b1;
        end
        if (d_hs) begin
            src_q.delete(0);
            beats_consumed++;
            if (beats_consumed == starve_at) gap = starve_len;
        end
        drive();
    endtask

    task automatic push_cmd(input logic [79:0] h, input logic [31:0] f0,
                            input logic [31:0] f1, input logic [31:0] f2);
        hdr_q.push_back('{h, exp_total});
        exp_q.push_back(f0);
        exp_q.push_back(f1);
        exp_q.push_back(f2);
        exp_total += 3;
    endtask

    task automatic push_beats(input int n, input int tag);
        logic [31:0] lo, hi;
        for (int k = 0; k < n; k++) begin
            lo = 32'hA000_0000 | 32'(tag << 8) | 32'(k);
            hi = 32'hB000_0000 | 32'(tag << 8) | 32'(k);
            src_q.push_back({hi, lo});
            exp_q.push_back(lo);
            exp_q.push_back(hi);
            exp_total += 2;
        end
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || hdr_q.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
            hdr_q.delete();
            exp_total = flits_done;
        end else begin
            check("hdr_ready_after", hready, 1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hdr_ready"}, hready, 1);
        check({tag, "_data_ready"}, dready, 0);
        check({tag, "_link_v"}, link_v, 0);
        check({tag, "_link_data"}, link_data, 0);
    endtask

    initial begin
        int b0, f0, n;
        reset_n = 1'b0;
        hv = 1'b0; dv = 1'b0; hdr = '0; data = '0; link_ready = 1'b1;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Read: 3 header flits only, stray beat must not be taken.
        dready_seen = 1'b0; b0 = beats_consumed; span_start = -1;
        push_cmd(80'h1111_2222_3333_4444_ABC0, 32'h4444_ABC0, 32'h2222_3333, 32'h0000_1111);
        src_q.push_back(64'hDEAD_0000_DEAD_0001);
        drive();
        drain(50);
        check("read_span", span_end - span_start + 1, 3);
        check("read_dready_seen", dready_seen, 0);
        check("read_beats", beats_consumed - b0, 0);
        src_q.delete();
        drive();

        // 8-beat write, back-to-back: 19 contiguous link cycles.
        b0 = beats_consumed; span_start = -1;
        push_cmd(80'hAAAA_BBBB_CCCC_DDDD_0061, 32'hDDDD_0061, 32'hBBBB_CCCC, 32'h0000_AAAA);
        push_beats(8, 2);
        drive();
        drain(100);
        check("wr8_span", span_end - span_start + 1, 19);
        check("wr8_beats", beats_consumed - b0, 8);

        // Uncached write, size 2, link_ready toggling 1,0,0,1.
        b0 = beats_consumed; f0 = flits_done; rdy_toggle = 1'b1; pidx = 0;
        push_cmd(80'h0123_4567_89AB_CDEF_0023, 32'hCDEF_0023, 32'h4567_89AB, 32'h0000_0123);
        src_q.push_back(64'hFEED_BEEF_CAFE_F00D);
        exp_q.push_back(32'hCAFE_F00D);
        exp_q.push_back(32'hFEED_BEEF);
        exp_total += 2;
        drive();
        drain(100);
        check("toggle_flits", flits_done - f0, 5);
        check("toggle_beats", beats_consumed - b0, 1);
        rdy_toggle = 1'b0;

        // Size-4 write with a 5-cycle source gap after beat 1, then an early
        // read header. Write spans 7 flits + 4 idle = 11 cycles, one IDLE
        // cycle, then 3 read flits: 15 cycles end to end.
        b0 = beats_consumed; span_start = -1;
        starve_at = beats_consumed + 1; starve_len = 5;
        push_cmd(80'h0000_0000_0000_0000_0041, 32'h0000_0041, 32'h0, 32'h0);
        push_beats(2, 4);
        src_q.push_back(64'h0BAD_0BAD_0BAD_0BAD);
        push_cmd(80'h5555_6666_7777_8888_9990, 32'h8888_9990, 32'h6666_7777, 32'h0000_5555);
        drive();
        drain(100);
        check("starve_span", span_end - span_start + 1, 15);
        check("starve_beats", beats_consumed - b0, 2);
        starve_at = -1;
        src_q.delete();
        drive();

        // Reset during beat 3 of an 8-beat write, then a fresh read.
        f0 = flits_done;
        push_cmd(80'hFFFF_EEEE_DDDD_CCCC_0061, 32'hCCCC_0061, 32'hEEEE_DDDD, 32'h0000_FFFF);
        push_beats(8, 5);
        drive();
        n = 0;
        while (flits_done < f0 + 8 && n < 100) begin
            tick();
            n++;
        end
        check("pre_reset_flits", flits_done - f0, 8);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete(); src_q.delete(); hdr_q.delete();
        exp_total = flits_done; gap = 0; lat_pend = 1'b0;
        drive();
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        span_start = -1;
        push_cmd(80'h1111_2222_3333_4444_ABC0, 32'h4444_ABC0, 32'h2222_3333, 32'h0000_1111);
        drive();
        drain(50);
        check("post_reset_span", span_end - span_start + 1, 3);

        // Illegal size 7 write: treated as 8 beats, 19 flits.
        b0 = beats_consumed; f0 = flits_done; span_start = -1;
        push_cmd(80'h7777_0000_1234_5678_9A71, 32'h5678_9A71, 32'h0000_1234, 32'h0000_7777);
        push_beats(8, 7);
        src_q.push_back(64'h0BAD_0BAD_0BAD_0BAD);
        drive();
        drain(100);
        check("size7_beats", beats_consumed - b0, 8);
        check("size7_flits", flits_done - f0, 19);
        check("size7_span", span_end - span_start + 1, 19);
        src_q.delete();
        drive();

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
